// File: rtl/morse_decoder_if.sv
// Morse decoder signal bundle: the keyed input and the decoded character /
// word-space outputs. The decoder takes the slave view; whoever drives the
// key and consumes characters takes the master view.
interface morse_decoder_if;
  logic       key_in;      // asynchronous key / tone envelope, 1 = mark
  logic       char_valid;  // one-cycle pulse: character decoded
  logic [5:0] char_bits;   // element i at bit i, 1 = dah
  logic [2:0] char_len;    // elements stored, 1..6
  logic       char_err;    // more than six elements were keyed
  logic       word_gap;    // one-cycle pulse: word space seen
  logic       busy;        // decoder not idle

  modport master (
    output key_in,
    input  char_valid, char_bits, char_len, char_err, word_gap, busy
  );

  modport slave (
    input  key_in,
    output char_valid, char_bits, char_len, char_err, word_gap, busy
  );
endinterface

// File: rtl/morse_decoder.sv
// Morse key decoder. Times marks and spaces in quarter-unit ticks, classifies
// marks as dit/dah, assembles up to six elements per character and reports
// character and word boundaries from the length of the following space.
module morse_decoder #(
  parameter int unsigned QUARTER_CYCLES = 750000  // clk cycles per quarter unit
) (
  input logic            clk,
  input logic            rst,
  morse_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_e;

  localparam logic [19:0] PRESC_LAST = 20'(QUARTER_CYCLES - 1);

  // Quarter-unit thresholds.
  localparam logic [7:0] GLITCH_Q = 8'd2;   // shorter marks are ignored
  localparam logic [7:0] DAH_Q    = 8'd8;   // marks at least this long are dahs
  localparam logic [7:0] CHAR_Q   = 8'd12;  // space length that ends a character
  localparam logic [7:0] WORD_Q   = 8'd28;  // space length that ends a word

  logic        key_meta_q, key_s_q;
  logic        armed_q;
  logic [19:0] presc_q, presc_d;
  logic [7:0]  qcnt_q, qcnt_d, qcnt_inc;
  logic        tick;
  state_e      state_q, state_d;
  logic [2:0]  sym_len_q, sym_len_d;
  logic [5:0]  sym_bits_q, sym_bits_d;
  logic        ovf_q, ovf_d;
  logic        word_pend_q, word_pend_d;
  logic        char_valid_q, char_valid_d;
  logic [5:0]  char_bits_q, char_bits_d;
  logic [2:0]  char_len_q, char_len_d;
  logic        char_err_q, char_err_d;
  logic        word_gap_q, word_gap_d;

  // Two-flop synchronizer for the key level; also tracks the arming condition.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    if (rst) begin
      // NOTE: the synchronizer resets to "mark" so a key held through reset
      // must be seen low before the decoder can arm.
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
      armed_q    <= 1'b0;
    end else begin
      key_meta_q <= bus.key_in;
      key_s_q    <= key_meta_q;
      if (!key_s_q) armed_q <= 1'b1;
    end
  end

  assign tick     = (presc_q == PRESC_LAST);
  // Count including a tick landing this cycle, so a mark is measured to the
  // cycle its falling edge is seen rather than one quarter late.
  assign qcnt_inc = (tick && qcnt_q != 8'hFF) ? qcnt_q + 8'd1 : qcnt_q;

  // Prescaler and quarter counter restart whenever the state changes.
  always_comb begin
    presc_d = tick ? 20'd0 : presc_q + 20'd1;
    qcnt_d  = qcnt_inc;
    if (state_d != state_q) begin
      presc_d = 20'd0;
      qcnt_d  = 8'd0;
    end
  end

  // Next-state, element assembly and character / word reporting.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d      = state_q;
    sym_len_d    = sym_len_q;
    sym_bits_d   = sym_bits_q;
    ovf_d        = ovf_q;
    word_pend_d  = word_pend_q;
    char_valid_d = 1'b0;
    char_bits_d  = char_bits_q;
    char_len_d   = char_len_q;
    char_err_d   = char_err_q;
    word_gap_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_s_q && armed_q) state_d = MARK;
      end

      MARK: begin
        if (!key_s_q) begin
          if (qcnt_inc < GLITCH_Q) begin
            state_d = (sym_len_q != 3'd0 || word_pend_q) ? SPACE : IDLE;
          end else begin
            if (sym_len_q < 3'd6) begin
              for (int i = 0; i < 6; i++) begin
                if (sym_len_q == 3'(i)) sym_bits_d[i] = (qcnt_inc >= DAH_Q);
              end
              sym_len_d = sym_len_q + 3'd1;
            end else begin
              ovf_d = 1'b1;
            end
            state_d = SPACE;
          end
        end
      end

      SPACE: begin
        if (qcnt_q == CHAR_Q && sym_len_q != 3'd0) begin
          char_valid_d = 1'b1;
          char_bits_d  = sym_bits_q;
          char_len_d   = sym_len_q;
          char_err_d   = ovf_q;
          sym_len_d    = 3'd0;
          sym_bits_d   = 6'd0;
          ovf_d        = 1'b0;
          word_pend_d  = 1'b1;
        end
        if (qcnt_q == WORD_Q && word_pend_q) begin
          word_gap_d  = 1'b1;
          word_pend_d = 1'b0;
          state_d     = IDLE;
        end
        if (key_s_q) state_d = MARK;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counters, character assembly and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      presc_q      <= 20'd0;
      qcnt_q       <= 8'd0;
      sym_len_q    <= 3'd0;
      sym_bits_q   <= 6'd0;
      ovf_q        <= 1'b0;
      word_pend_q  <= 1'b0;
      char_valid_q <= 1'b0;
      char_bits_q  <= 6'd0;
      char_len_q   <= 3'd0;
      char_err_q   <= 1'b0;
      word_gap_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      qcnt_q       <= qcnt_d;
      sym_len_q    <= sym_len_d;
      sym_bits_q   <= sym_bits_d;
      ovf_q        <= ovf_d;
      word_pend_q  <= word_pend_d;
      char_valid_q <= char_valid_d;
      char_bits_q  <= char_bits_d;
      char_len_q   <= char_len_d;
      char_err_q   <= char_err_d;
      word_gap_q   <= word_gap_d;
    end
  end

  assign bus.char_valid = char_valid_q;
  assign bus.char_bits  = char_bits_q;
  assign bus.char_len   = char_len_q;
  assign bus.char_err   = char_err_q;
  assign bus.word_gap   = word_gap_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
